flp_norm_arb: RTL and testbench
===============================

// Module: flp_norm_arb
// PURPOSE
//  Shares one combinational flp_norm (FP32 significand normalizer) between NREQ requesters.
//  Round-robin arbitration picks one operand per cycle. A 2-stage registered pipeline
//  carries the operand, then the normalized result, tagged with the requester id.
//  Sits between the FP unit pre-normalize stages and the rounding/pack stage.
// PARAMETERS
//  NREQ     4   number of requesters (>=2)
//  INWIDTH  32  raw significand width presented by requesters
//  EWIDTH   8   exponent width (o_res_exd is EWIDTH+2 bits)
//  SWIDTH   23  fraction width (o_res_sg is SWIDTH+RSWIDTH+1 bits)
//  RSWIDTH  2   round/sticky bits kept by normalizer
//  IDW      $clog2(NREQ) (localparam) requester id width
// PORTS
//  clk        in   1                    clock, all state on posedge
//  rst        in   1                    async active-high reset
//  i_req_vld  in   NREQ                 per-requester operand valid
//  i_req_sg   in   NREQ*INWIDTH         operands, requester n at [n*INWIDTH +: INWIDTH]
//  o_req_rdy  out  NREQ                 one-hot grant/accept; transfer = vld&rdy
//  o_res_vld  out  1                    result valid
//  i_res_rdy  in   1                    consumer ready; result transfer = vld&rdy
//  o_res_sg   out  SWIDTH+RSWIDTH+1     normalized significand from flp_norm
//  o_res_exd  out  EWIDTH+2             exponent adjustment from flp_norm
//  o_res_id   out  IDW                  requester id of this result
//  o_busy     out  1                    any pipeline stage valid
// BEHAVIOUR
//  - Reset (async, rst=1): s1_vld=0, s2_vld=0, o_res_sg/exd/id=0, rr_ptr=0. o_req_rdy=0 while rst=1.
//  - Pipeline advance: adv2 = !s2_vld | i_res_rdy; adv1 = !s1_vld | adv2.
//  - Grant: when adv1=1, pick first n with i_req_vld[n]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    o_req_rdy=onehot(n). No grant when adv1=0 or no vld. o_req_rdy is combinational from vld/state.
//  - Accept edge: s1_sg<=operand n, s1_id<=n, s1_vld<=1, rr_ptr<=(n+1) mod NREQ (wraps NREQ-1 -> 0).
//    rr_ptr holds when nothing is accepted.
//  - s1 -> s2 when adv2: o_res_sg/o_res_exd<=flp_norm(s1_sg), o_res_id<=s1_id, s2_vld<=s1_vld.
//    If adv1 and no grant, s1_vld<=0.
//  - Latency: operand accepted at edge k -> o_res_vld=1 after edge k+1. Throughput 1/cycle with i_res_rdy=1.
//  - Stall: while o_res_vld&!i_res_rdy, o_res_* hold stable.
//    s1 fills once and then holds; no grants while both stages are full. No loss, no duplication.
//  - Simultaneous result pop and operand accept in one cycle: both occur (full-throughput case).
//  - Requester rules: a requester holds i_req_sg stable while vld&!rdy. Dropping vld before grant is legal.
//  - Results leave in acceptance order. Ids are exact.
//  - Reset mid-operation: in-flight operands are discarded, no result emitted, arbitration restarts at 0.
//  - Zero operand is passed through the normalizer unchanged in semantics (flp_norm defines output).
// STRUCTURE
//  - Shared FP package/header: FP32 widths (EWIDTH=8, SWIDTH=23, RSWIDTH=2, INWIDTH=32)
//    and derived output widths, shared with flp_norm and other flp_* blocks.
//  - Sub-module flp_rr_arb: NREQ-wide round-robin arbiter (i_req, i_en -> o_gnt one-hot,
//    internal rr_ptr, async rst).
//  - flp_norm instanced once, combinational, between s1 and s2 registers.
// TESTING
//  1 Single req: req0 sg=32'h0080_0000, i_res_rdy=1 -> o_req_rdy=4'b0001 same cycle;
//    o_res_vld 2 edges later; sg/exd equal standalone flp_norm(32'h0080_0000); id=0.
//  2 All 4 vld every cycle, i_res_rdy=1 -> grants 0,1,2,3,0,... one per cycle.
//    Results carry ids 0,1,2,3 back to back.
//  3 Backpressure: stream 32'h0200_0000 (id1), then 32'h0800_0000 (id2), then 32'h0800_0001 (id3),
//    with i_res_rdy=0 for 5 cycles -> o_res_* frozen on id1; s1 holds id2; no grant to id3.
//    After release, the id1, id2, id3 results pop in order.
//  4 Wrap: rr_ptr=3, vld={0,0,0,1} (req0 only) -> req0 granted, rr_ptr=1.
//    Then vld=4'b1111 -> req1 granted next.
//  5 Reset mid-flight: assert rst with s1 and s2 valid -> o_res_vld=0 immediately (async);
//    after release, no stale result; first grant goes to req0.
//  6 Zero/edge operands 32'h0000_0000, 32'h0800_0002 via req2 -> outputs match flp_norm model; id=2.

Source files
------------

// File: rtl/flp_norm_arb_pkg.sv
// FP32 field widths shared by the flp_* blocks, plus the derived
// normalizer output widths.
package flp_norm_arb_pkg;

    localparam int FLP_EWIDTH  = 8;
    localparam int FLP_SWIDTH  = 23;
    localparam int FLP_RSWIDTH = 2;
    localparam int FLP_INWIDTH = 32;

    // hidden bit + fraction + round/sticky
    localparam int FLP_SGW  = FLP_SWIDTH + FLP_RSWIDTH + 1;
    localparam int FLP_EXDW = FLP_EWIDTH + 2;

endpackage

// File: rtl/flp_norm.sv
// Combinational significand normalizer.
// The leading one is moved to the MSB and the result is cut to hidden+fraction+round
// bits, with the dropped bits ORed into a sticky LSB. o_exd is the signed distance of
// the leading one from the nominal hidden-bit position SWIDTH. A zero input gives zero
// on both outputs.
module flp_norm
    import flp_norm_arb_pkg::*;
#(
    parameter int INWIDTH = FLP_INWIDTH,
    parameter int EWIDTH  = FLP_EWIDTH,
    parameter int SWIDTH  = FLP_SWIDTH,
    parameter int RSWIDTH = FLP_RSWIDTH
) (
    input  logic [INWIDTH-1:0]             i_sg,
    output logic [SWIDTH+RSWIDTH:0]        o_sg,
    output logic [EWIDTH+1:0]              o_exd
);
    localparam int KEEP = SWIDTH + RSWIDTH;
    localparam int EXDW = EWIDTH + 2;

    logic [INWIDTH-1:0] norm;
    logic               found;
    int                 lead;

    always_comb begin
        found = 1'b0;
        lead  = 0;
        for (int i = INWIDTH - 1; i >= 0; i--) begin
            if (!found && i_sg[i]) begin
                found = 1'b1;
                lead  = i;
            end
        end
        norm  = i_sg << (INWIDTH - 1 - lead);
        o_sg  = {norm[INWIDTH-1 -: KEEP], |norm[INWIDTH-KEEP-1:0]};
        o_exd = found ? EXDW'(lead - SWIDTH) : '0;
    end

endmodule

// File: rtl/flp_rr_arb.sv
// Round-robin arbiter. The search starts at rr_ptr; after a grant to n the pointer
// moves to n+1 (wrapping). Nothing is granted while i_en is low.
module flp_rr_arb
    import flp_norm_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_gnt_id
);
    logic [IDW-1:0] rr_ptr;
    logic           hit;
    int             idx;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        hit      = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (i_en && !hit && i_req[idx]) begin
                hit        = 1'b1;
                o_gnt[idx] = 1'b1;
                o_gnt_id   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (hit)
            rr_ptr <= (o_gnt_id == IDW'(NREQ - 1)) ? '0 : o_gnt_id + IDW'(1);
    end

endmodule

// File: rtl/flp_norm_arb.sv
// Shares one flp_norm between NREQ requesters. Stage 1 holds the granted operand;
// stage 2 holds the normalized result. Both stages stall under result backpressure.
module flp_norm_arb
    import flp_norm_arb_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int INWIDTH = FLP_INWIDTH,
    parameter  int EWIDTH  = FLP_EWIDTH,
    parameter  int SWIDTH  = FLP_SWIDTH,
    parameter  int RSWIDTH = FLP_RSWIDTH,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           i_req_vld,
    input  logic [NREQ*INWIDTH-1:0]   i_req_sg,
    output logic [NREQ-1:0]           o_req_rdy,
    output logic                      o_res_vld,
    input  logic                      i_res_rdy,
    output logic [SWIDTH+RSWIDTH:0]   o_res_sg,
    output logic [EWIDTH+1:0]         o_res_exd,
    output logic [IDW-1:0]            o_res_id,
    output logic                      o_busy
);
    logic [NREQ-1:0][INWIDTH-1:0] req_sg;
    logic [2:1]                   vld_pipe;   // [1] operand stage, [2] result stage
    logic                         adv1, adv2;
    logic [NREQ-1:0]              gnt;
    logic [IDW-1:0]               gnt_id;
    logic [INWIDTH-1:0]           s1_sg;
    logic [IDW-1:0]               s1_id;
    logic [SWIDTH+RSWIDTH:0]      norm_sg;
    logic [EWIDTH+1:0]            norm_exd;

    assign req_sg = i_req_sg;
    assign adv2   = !vld_pipe[2] || i_res_rdy;
    assign adv1   = !vld_pipe[1] || adv2;

    // Gating with rst keeps o_req_rdy low for the whole reset pulse.
    flp_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req_vld),
        .i_en     (adv1 && !rst),
        .o_gnt    (gnt),
        .o_gnt_id (gnt_id)
    );

    flp_norm #(
        .INWIDTH (INWIDTH),
        .EWIDTH  (EWIDTH),
        .SWIDTH  (SWIDTH),
        .RSWIDTH (RSWIDTH)
    ) u_norm (
        .i_sg  (s1_sg),
        .o_sg  (norm_sg),
        .o_exd (norm_exd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            s1_sg     <= '0;
            s1_id     <= '0;
            o_res_sg  <= '0;
            o_res_exd <= '0;
            o_res_id  <= '0;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= |gnt;
                if (|gnt) begin
                    s1_sg <= req_sg[gnt_id];
                    s1_id <= gnt_id;
                end
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    o_res_sg  <= norm_sg;
                    o_res_exd <= norm_exd;
                    o_res_id  <= s1_id;
                end
            end
        end
    end

    assign o_req_rdy = gnt;
    assign o_res_vld = vld_pipe[2];
    assign o_busy    = |vld_pipe;

endmodule

// File: tb/tb_flp_norm_arb.sv
// Bench for flp_norm_arb: directed scenarios followed by a random phase, all checked
// against an in-order queue model of results and an arithmetic normalizer model.
module tb_flp_norm_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_vld;
    logic [31:0]  req_sg [4];
    logic [127:0] req_sg_flat;
    logic         res_rdy;
    logic [3:0]   o_req_rdy;
    logic         o_res_vld;
    logic [25:0]  o_res_sg;
    logic [9:0]   o_res_exd;
    logic [1:0]   o_res_id;
    logic         o_busy;

    assign req_sg_flat = {req_sg[3], req_sg[2], req_sg[1], req_sg[0]};

    always #5 clk = ~clk;

    flp_norm_arb dut (
        .clk       (clk),
        .rst       (rst),
        .i_req_vld (req_vld),
        .i_req_sg  (req_sg_flat),
        .o_req_rdy (o_req_rdy),
        .o_res_vld (o_res_vld),
        .i_res_rdy (res_rdy),
        .o_res_sg  (o_res_sg),
        .o_res_exd (o_res_exd),
        .o_res_id  (o_res_id),
        .o_busy    (o_busy)
    );

    typedef struct {
        logic [25:0] sg;
        logic [9:0]  exd;
        int          id;
        int          stamp;
    } item_t;

    item_t      q[$];
    int         mptr = 0;
    int         edge_no = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_gnt;

    // Leading one moved to bit 31, keep 25 bits, OR the rest into a sticky bit.
    function automatic void ref_norm(input logic [31:0] x, output logic [25:0] sg,
                                     output logic [9:0] exd);
        int              lead;
        longint unsigned n;
        if (x == 0) begin
            sg  = '0;
            exd = '0;
            return;
        end
        lead = 0;
        for (int k = 0; k < 32; k++)
            if ((x >> k) != 0) lead = k;
        n   = longint'(x) * (64'd1 << (31 - lead));
        sg  = 26'((n / 128) * 2 + (((n % 128) != 0) ? 1 : 0));
        exd = 10'(lead - 23);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, take the edge, update the model.
    task automatic cyc();
        logic [3:0]  eg;
        logic        vis;
        int          gid;
        logic [25:0] rsg;
        logic [9:0]  rexd;
        #1;
        eg  = '0;
        gid = -1;
        vis = !rst && q.size() > 0 && q[0].stamp < edge_no;
        if (!rst && !(q.size() == 2 && !res_rdy)) begin
            for (int k = 0; k < 4; k++) begin
                if (gid < 0 && req_vld[(mptr + k) % 4]) gid = (mptr + k) % 4;
            end
        end
        if (gid >= 0) eg[gid] = 1'b1;
        last_gnt = eg;
        chk("req_rdy", 32'(o_req_rdy), 32'(eg));
        chk("res_vld", 32'(o_res_vld), 32'(vis));
        chk("busy", 32'(o_busy), 32'(!rst && q.size() > 0));
        if (vis) begin
            chk("res_sg", 32'(o_res_sg), 32'(q[0].sg));
            chk("res_exd", 32'(o_res_exd), 32'(q[0].exd));
            chk("res_id", 32'(o_res_id), 32'(q[0].id));
        end
        if (gid >= 0) ref_norm(req_sg[gid], rsg, rexd);
        @(posedge clk);
        if (!rst) begin
            edge_no++;
            if (vis && res_rdy) void'(q.pop_front());
            if (gid >= 0) begin
                q.push_back('{sg: rsg, exd: rexd, id: gid, stamp: edge_no});
                mptr = (gid + 1) % 4;
            end
        end
        #1;
    endtask

    task automatic wait_res(input string tag, input logic [25:0] sg, input logic [9:0] exd,
                            input logic [1:0] id);
        for (int k = 0; k < 8 && !o_res_vld; k++) cyc();
        chk({tag, "_vld"}, 32'(o_res_vld), 32'd1);
        chk({tag, "_sg"}, 32'(o_res_sg), 32'(sg));
        chk({tag, "_exd"}, 32'(o_res_exd), 32'(exd));
        chk({tag, "_id"}, 32'(o_res_id), 32'(id));
    endtask

    task automatic grant_step(input string tag, input logic [3:0] vld, input logic [3:0] exp);
        req_vld = vld;
        #1;
        chk(tag, 32'(o_req_rdy), 32'(exp));
        cyc();
    endtask

    initial begin
        rst     = 1'b1;
        req_vld = 4'b1111;
        res_rdy = 1'b1;
        for (int n = 0; n < 4; n++) req_sg[n] = 32'h0080_0000;
        #2;
        chk("rst_req_rdy", 32'(o_req_rdy), 32'd0);
        chk("rst_res_vld", 32'(o_res_vld), 32'd0);
        chk("rst_res_sg", 32'(o_res_sg), 32'd0);
        chk("rst_res_id", 32'(o_res_id), 32'd0);
        cyc();
        cyc();
        rst     = 1'b0;
        req_vld = 4'b0000;
        cyc();

        // single request, latency and known normalizer value
        req_vld   = 4'b0001;
        req_sg[0] = 32'h0080_0000;
        cyc();
        req_vld = 4'b0000;
        cyc();
        chk("t1_vld", 32'(o_res_vld), 32'd1);
        chk("t1_sg", 32'(o_res_sg), 32'h0200_0000);
        chk("t1_exd", 32'(o_res_exd), 32'd0);
        chk("t1_id", 32'(o_res_id), 32'd0);
        cyc();

        // all requesters valid, full throughput
        req_vld = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            for (int n = 0; n < 4; n++) req_sg[n] = $urandom;
            cyc();
        end
        req_vld = 4'b0000;
        cyc();
        cyc();

        // backpressure: id1 frozen on the output, id2 in s1, id3 starved
        req_vld   = 4'b0010;
        req_sg[1] = 32'h0200_0000;
        cyc();
        req_vld   = 4'b0100;
        req_sg[2] = 32'h0800_0000;
        res_rdy   = 1'b0;
        cyc();
        req_vld   = 4'b1000;
        req_sg[3] = 32'h0800_0001;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_no_grant", 32'(o_req_rdy), 32'd0);
            chk("bp_hold_id", 32'(o_res_id), 32'd1);
        end
        res_rdy = 1'b1;
        cyc();
        req_vld = 4'b0000;
        for (int i = 0; i < 4; i++) cyc();

        // pointer wrap: 2 -> ptr 3, then req0 alone wraps to ptr 1
        grant_step("wrap_g2", 4'b0100, 4'b0100);
        grant_step("wrap_g0", 4'b0001, 4'b0001);
        grant_step("wrap_g1", 4'b1111, 4'b0010);
        req_vld = 4'b0000;
        for (int i = 0; i < 3; i++) cyc();

        // zero and sticky operands through req2
        req_vld   = 4'b0100;
        req_sg[2] = 32'h0000_0000;
        cyc();
        req_sg[2] = 32'h0800_0002;
        cyc();
        req_vld = 4'b0000;
        wait_res("zero", 26'h0, 10'h0, 2'd2);
        cyc();
        wait_res("edge", 26'h200_0001, 10'd4, 2'd2);
        cyc();
        cyc();

        // reset with both stages full
        req_vld = 4'b1111;
        res_rdy = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(o_res_vld), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_rdy", 32'(o_req_rdy), 32'd0);
        q.delete();
        mptr = 0;
        cyc();
        rst     = 1'b0;
        res_rdy = 1'b1;
        grant_step("post_rst_g0", 4'b1111, 4'b0001);
        for (int i = 0; i < 3; i++) cyc();

        // random traffic; sg stays stable while a request is pending
        last_gnt = '0;
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 4; n++) begin
                if (!req_vld[n] || last_gnt[n]) begin
                    req_vld[n] = ($urandom_range(0, 2) != 0);
                    req_sg[n]  = $urandom >> $urandom_range(0, 31);
                end else if ($urandom_range(0, 9) == 0) begin
                    req_vld[n] = 1'b0;
                end
            end
            res_rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        req_vld = 4'b0000;
        res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("drained", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
